// File: rtl/layer_controller.sv
// Layer sequencer for a P-wide neuron array: walks G = M/P neuron groups and issues
// clear / accumulate / bias / store for each, then a one-cycle ready pulse.
module layer_controller #(
  parameter int N = 10,
  parameter int M = 8,
  parameter int P = 2,
  localparam int G  = M / P,
  localparam int OW = (N > 1) ? $clog2(N) : 1,
  localparam int GW = (G > 1) ? $clog2(G) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic [OW-1:0] offset,
  output logic [GW-1:0] group,
  output logic          clr,
  output logic          ld,
  output logic          bias_ld,
  output logic          store,
  output logic          busy,
  output logic          ready
);

  generate
    if (N < 2) begin : g_bad_n
      $error("layer_controller: N must be at least 2");
    end
    if (P < 1 || (M % P) != 0) begin : g_bad_mp
      $error("layer_controller: M must be a non-zero multiple of P");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    BIAS  = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [OW-1:0] OFF_LAST = OW'(N - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(G - 1);

  state_t        state_reg;
  logic [OW-1:0] offset_reg;
  logic [GW-1:0] group_reg;
  logic          clr_reg;
  logic          bias_ld_reg;
  logic          store_reg;
  logic          busy_reg;
  logic          ready_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      offset_reg  <= '0;
      group_reg   <= '0;
      clr_reg     <= 1'b0;
      bias_ld_reg <= 1'b0;
      store_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      ready_reg   <= 1'b0;
    end else if (abort && state_reg != IDLE) begin
      // Abort beats every transition, including the last store and DONE.
      state_reg   <= IDLE;
      offset_reg  <= '0;
      group_reg   <= '0;
      clr_reg     <= 1'b0;
      bias_ld_reg <= 1'b0;
      store_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      ready_reg   <= 1'b0;
    end else begin
      // Strobes are single-cycle; each case arm raises the one for the state it enters.
      clr_reg     <= 1'b0;
      bias_ld_reg <= 1'b0;
      store_reg   <= 1'b0;
      ready_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            state_reg  <= CLEAR;
            offset_reg <= '0;
            group_reg  <= '0;
            clr_reg    <= 1'b1;
            busy_reg   <= 1'b1;
          end
        end
        CLEAR: begin
          state_reg <= ACCUM;
        end
        ACCUM: begin
          if (in_valid) begin
            if (offset_reg == OFF_LAST) begin
              state_reg   <= BIAS;
              offset_reg  <= '0;
              bias_ld_reg <= 1'b1;
            end else begin
              offset_reg <= offset_reg + 1'b1;
            end
          end
        end
        BIAS: begin
          state_reg <= STORE;
          store_reg <= 1'b1;
        end
        STORE: begin
          if (group_reg == GRP_LAST) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
          end else begin
            state_reg <= CLEAR;
            group_reg <= group_reg + 1'b1;
            clr_reg   <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          group_reg <= '0;
        end
        default: begin
          state_reg  <= IDLE;
          offset_reg <= '0;
          group_reg  <= '0;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  // ld follows in_valid directly so a stalled sample never accumulates.
  assign ld      = (state_reg == ACCUM) && in_valid;
  assign offset  = offset_reg;
  assign group   = group_reg;
  assign clr     = clr_reg;
  assign bias_ld = bias_ld_reg;
  assign store   = store_reg;
  assign busy    = busy_reg;
  assign ready   = ready_reg;

endmodule

// File: tb/tb_layer_controller.sv
// Self-checking bench for layer_controller (N=4, M=6, P=2): directed scenarios plus
// random traffic compared against a layer-position reference model.
module tb_layer_controller;

  localparam int TN = 4;
  localparam int TM = 6;
  localparam int TP = 2;
  localparam int TG = TM / TP;
  localparam int GL = TN + 3;        // cycles per group
  localparam int TD = TG * GL + 1;   // layer position of the ready cycle

  logic       clk = 1'b0;
  logic       rst, start, abort, in_valid;
  logic [1:0] offset;
  logic [1:0] group;
  logic       clr, ld, bias_ld, store, busy, ready;

  layer_controller #(.N(TN), .M(TM), .P(TP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
    .offset(offset), .group(group), .clr(clr), .ld(ld), .bias_ld(bias_ld),
    .store(store), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int mdl_t = 0;       // 0 = idle, 1..TD = position within the layer
  int ncyc, ready_at, ready_cnt, store_cnt, busy_cnt, ld_cnt, clr_cnt, bias_cnt;
  int store_grp[$];
  int ready_times[$];
  logic [9:0] obs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs from the layer position: each group is clear, N accumulates, bias, store.
  function automatic logic [9:0] model_out(input int t, input logic iv);
    logic b, r, c, l, bl, s;
    int g, p, off;
    b = 0; r = 0; c = 0; l = 0; bl = 0; s = 0; g = 0; off = 0;
    if (t == TD) begin
      r = 1; g = TG - 1;
    end else if (t > 0) begin
      g = (t - 1) / GL;
      p = (t - 1) % GL;
      b = 1;
      if (p == 0) c = 1;
      else if (p <= TN) begin off = p - 1; l = iv; end
      else if (p == TN + 1) bl = 1;
      else s = 1;
    end
    return {b, r, c, l, bl, s, 2'(g), 2'(off)};
  endfunction

  function automatic int model_next(input int t, input logic st, input logic ab,
                                    input logic iv, input logic rs);
    int p;
    if (rs) return 0;
    if (t == 0) return (st && !ab) ? 1 : 0;
    if (ab || t == TD) return 0;
    p = (t - 1) % GL;
    if (p >= 1 && p <= TN && !iv) return t;
    return t + 1;
  endfunction

  task automatic step(input logic st, input logic ab, input logic iv, input logic rs);
    start = st; abort = ab; in_valid = iv; rst = rs;
    #1;
    obs = {busy, ready, clr, ld, bias_ld, store, group, offset};
    check_eq("outputs", 32'(obs), 32'(model_out(mdl_t, iv)));
    if (ready) begin ready_cnt++; ready_at = ncyc; ready_times.push_back(ncyc); end
    if (store) begin store_cnt++; store_grp.push_back(int'(group)); end
    if (busy) busy_cnt++;
    if (ld) ld_cnt++;
    if (clr) clr_cnt++;
    if (bias_ld) bias_cnt++;
    @(posedge clk);
    mdl_t = model_next(mdl_t, st, ab, iv, rs);
    ncyc++;
    @(negedge clk);
  endtask

  task automatic begin_layer();
    ncyc = 0; ready_at = -1; ready_cnt = 0; store_cnt = 0; busy_cnt = 0;
    ld_cnt = 0; clr_cnt = 0; bias_cnt = 0;
    store_grp.delete();
    ready_times.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mdl_t = 0;
    begin_layer();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("reset_state", 32'(obs), 32'd0);

    // Plain layer with in_valid held high.
    begin_layer();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (25) step(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("basic_ready_cycle", 32'(ready_at), 32'd22);
    check_eq("basic_ready_cnt", 32'(ready_cnt), 32'd1);
    check_eq("basic_busy_cycles", 32'(busy_cnt), 32'd21);
    check_eq("basic_clr_cnt", 32'(clr_cnt), 32'd3);
    check_eq("basic_ld_cnt", 32'(ld_cnt), 32'd12);
    check_eq("basic_bias_cnt", 32'(bias_cnt), 32'd3);
    check_eq("basic_store_cnt", 32'(store_cnt), 32'd3);
    for (int i = 0; i < store_grp.size(); i++)
      check_eq("basic_store_group", 32'(store_grp[i]), 32'(i));
    $display("layer basic: ready at cycle %0d, %0d stores", ready_at, store_cnt);

    // Three-cycle stall at offset 2 of group 0.
    begin_layer();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c < 30; c++) begin
      logic iv;
      iv = !(c >= 4 && c <= 6);
      step(1'b0, 1'b0, iv, 1'b0);
      if (!iv) begin
        check_eq("stall_offset", 32'(obs[1:0]), 32'd2);
        check_eq("stall_ld", 32'(obs[6]), 32'd0);
      end
    end
    check_eq("stall_ready_cycle", 32'(ready_at), 32'd25);
    check_eq("stall_ready_cnt", 32'(ready_cnt), 32'd1);
    $display("layer stall: ready at cycle %0d", ready_at);

    // Abort during ACCUM of group 1.
    begin_layer();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      step(1'b0, c == 10, 1'b1, 1'b0);
      if (c == 10) check_eq("abort_in_group1", 32'(obs[3:2]), 32'd1);
      if (c == 11) check_eq("abort_idle", 32'(obs), 32'd0);
    end
    check_eq("abort_no_ready", 32'(ready_cnt), 32'd0);
    check_eq("abort_store_cnt", 32'(store_cnt), 32'd1);
    $display("layer abort: %0d stores, %0d ready pulses", store_cnt, ready_cnt);

    // start re-pulsed while busy and in DONE is ignored.
    begin_layer();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 30; c++)
      step(c == 5 || c == 15 || c == 21 || c == 22, 1'b0, 1'b1, 1'b0);
    check_eq("restart_ready_cnt", 32'(ready_cnt), 32'd1);
    check_eq("restart_ready_cycle", 32'(ready_at), 32'd22);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("start_abort_idle", 32'({obs[9], obs[7]}), 32'd0);
    $display("layer restart: ready at cycle %0d, start+abort stayed idle", ready_at);

    // Synchronous reset in STORE of group 0, start ignored while held.
    begin_layer();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 7; c++) step(1'b0, 1'b0, 1'b1, c == 7);
    check_eq("rst_store_seen", 32'(store_cnt), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("rst_outputs_zero", 32'(obs), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("rst_start_ignored", 32'(obs), 32'd0);
    begin_layer();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (25) step(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("rst_relayer_ready", 32'(ready_at), 32'd22);
    check_eq("rst_relayer_stores", 32'(store_cnt), 32'd3);
    $display("layer after reset: ready at cycle %0d", ready_at);

    // start held high: back-to-back layers every 23 cycles.
    begin_layer();
    repeat (70) step(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("cont_ready_cnt", 32'(ready_times.size()), 32'd3);
    for (int i = 0; i < ready_times.size(); i++)
      check_eq("cont_ready_cycle", 32'(ready_times[i]), 32'(22 + 23 * i));
    step(1'b0, 1'b1, 1'b1, 1'b0);
    $display("layer continuous: %0d ready pulses", ready_times.size());

    // Random traffic against the model.
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    $display("random phase: 500 cycles");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
